// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-RAM arbiter: CPU and DMA requester ports, the RAM
// array port and the end-of-program dump port.
interface dmem_arbiter_if #(
    parameter int AW = 9
);
    logic          StopM;
    logic          CpuReq;
    logic          CpuWE;
    logic [31:0]   CpuAddr;
    logic [31:0]   CpuWD;
    logic          CpuStall;
    logic [31:0]   CpuRData;
    logic          CpuRValid;
    logic          DmaReq;
    logic          DmaWE;
    logic [31:0]   DmaAddr;
    logic [31:0]   DmaWD;
    logic          DmaGnt;
    logic [31:0]   DmaRData;
    logic          DmaRValid;
    logic          RamWE;
    logic [AW-1:0] RamAddr;
    logic [31:0]   RamWD;
    logic [31:0]   RamRD;
    logic          DumpValid;
    logic [AW-1:0] DumpAddr;
    logic [31:0]   DumpData;
    logic          DumpDone;
    logic          AddrErr;

    modport slave (
        input  StopM, CpuReq, CpuWE, CpuAddr, CpuWD,
        input  DmaReq, DmaWE, DmaAddr, DmaWD, RamRD,
        output CpuStall, CpuRData, CpuRValid,
        output DmaGnt, DmaRData, DmaRValid,
        output RamWE, RamAddr, RamWD,
        output DumpValid, DumpAddr, DumpData, DumpDone, AddrErr
    );

    modport master (
        output StopM, CpuReq, CpuWE, CpuAddr, CpuWD,
        output DmaReq, DmaWE, DmaAddr, DmaWD, RamRD,
        input  CpuStall, CpuRData, CpuRValid,
        input  DmaGnt, DmaRData, DmaRValid,
        input  RamWE, RamAddr, RamWD,
        input  DumpValid, DumpAddr, DumpData, DumpDone, AddrErr
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM controller: round-robin CPU/DMA arbitration with a
// registered read return, and an end-of-program drain + full RAM dump sequencer.
module dmem_arbiter #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          CLK,
    input  logic          RST,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DUMP, ST_DONE} state_e;

    state_e        state_q, state_d;
    logic          rr_q, rr_d;              // 1: DMA wins the next tie
    logic          rd_pend_q, rd_pend_d;
    logic          rd_dma_q, rd_dma_d;
    logic          rd_ill_q, rd_ill_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dma_rdata_q, dma_rdata_d;
    logic [AW-1:0] dump_cnt_q, dump_cnt_d;
    logic [AW-1:0] dump_addr_q, dump_addr_d;
    logic          dump_vld_q, dump_vld_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          cpu_grant, dma_grant, any_grant;
    logic          g_we, g_ill;
    logic [31:0]   g_addr, g_wd, rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          cpu_rvalid, dma_rvalid;
    logic [31:0]   cpu_rdata, dma_rdata;

    function automatic logic addr_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (|a[31:AW+2]);
    endfunction

    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (state_q == ST_RUN && !bus.StopM) begin
            if (bus.CpuReq && (!bus.DmaReq || !rr_q))
                cpu_grant = 1'b1;
            else if (bus.DmaReq)
                dma_grant = 1'b1;
        end
        any_grant = cpu_grant | dma_grant;

        g_we   = cpu_grant ? bus.CpuWE   : bus.DmaWE;
        g_addr = cpu_grant ? bus.CpuAddr : bus.DmaAddr;
        g_wd   = cpu_grant ? bus.CpuWD   : bus.DmaWD;
        g_ill  = addr_illegal(g_addr);

        // Illegal accesses are consumed silently: no RAM strobe, address parked at 0.
        ram_we   = any_grant & g_we & ~g_ill;
        ram_addr = '0;
        if (state_q == ST_DUMP)
            ram_addr = dump_cnt_q;
        else if (any_grant && !g_ill)
            ram_addr = g_addr[AW+1:2];

        rd_data    = rd_ill_q ? 32'h0 : bus.RamRD;
        cpu_rvalid = rd_pend_q & ~rd_dma_q;
        dma_rvalid = rd_pend_q &  rd_dma_q;
        cpu_rdata  = cpu_rvalid ? rd_data : cpu_rdata_q;
        dma_rdata  = dma_rvalid ? rd_data : dma_rdata_q;

        rd_pend_d   = any_grant & ~g_we;
        rd_dma_d    = dma_grant;
        rd_ill_d    = g_ill;
        rr_d        = cpu_grant ? 1'b1 : (dma_grant ? 1'b0 : rr_q);
        err_d       = err_q | (any_grant & g_ill);
        cpu_rdata_d = cpu_rdata;
        dma_rdata_d = dma_rdata;

        state_d     = state_q;
        dump_cnt_d  = dump_cnt_q;
        dump_addr_d = dump_addr_q;
        dump_vld_d  = 1'b0;
        done_d      = done_q | ((state_q == ST_DONE) & dump_vld_q);

        case (state_q)
            ST_RUN:   if (bus.StopM) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DUMP;
            ST_DUMP: begin
                dump_vld_d  = 1'b1;
                dump_addr_d = dump_cnt_q;
                dump_cnt_d  = dump_cnt_q + 1'b1;
                if (dump_cnt_q == AW'(DEPTH - 1))
                    state_d = ST_DONE;
            end
            default:  state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            rr_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_dma_q    <= 1'b0;
            rd_ill_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            dump_cnt_q  <= '0;
            dump_addr_q <= '0;
            dump_vld_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rd_pend_q   <= rd_pend_d;
            rd_dma_q    <= rd_dma_d;
            rd_ill_q    <= rd_ill_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            dump_cnt_q  <= dump_cnt_d;
            dump_addr_q <= dump_addr_d;
            dump_vld_q  <= dump_vld_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.CpuStall  = bus.CpuReq & ~cpu_grant;
    assign bus.DmaGnt    = dma_grant;
    assign bus.CpuRValid = cpu_rvalid;
    assign bus.CpuRData  = cpu_rdata;
    assign bus.DmaRValid = dma_rvalid;
    assign bus.DmaRData  = dma_rdata;
    assign bus.RamWE     = ram_we;
    assign bus.RamAddr   = ram_addr;
    assign bus.RamWD     = ram_we ? g_wd : 32'h0;
    assign bus.DumpValid = dump_vld_q;
    assign bus.DumpAddr  = dump_addr_q;
    assign bus.DumpData  = dump_vld_q ? bus.RamRD : 32'h0;
    assign bus.DumpDone  = done_q;
    assign bus.AddrErr   = err_q;

endmodule
